// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and timing sequencer for an external async SRAM.
// Every SRAM-side output comes straight from a flop, so the strobes are glitch-free.
module sram_arbiter #(
   parameter int unsigned ADDR_W      = 19,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic [ADDR_W-1:0] sram_adr,
   output logic [DATA_W-1:0] sram_dat_o,
   input  logic [DATA_W-1:0] sram_dat_i,
   output logic              sram_dat_oe,
   output logic              sram_cs_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;          // latched access direction
   logic              port_q, port_d;      // latched granted port
   logic              last_grant_q, last_grant_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] dat_o_q, dat_o_d;
   logic              dat_oe_q, dat_oe_d;
   logic              cs_n_q, cs_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic              rsp0_valid_q, rsp0_valid_d;
   logic              rsp1_valid_q, rsp1_valid_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic              grant;
   logic              accept;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Round-robin grant: a lone requester wins, a tie goes to the port not served last.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
      req0_ready = rst_n & (state_q == StIdle) & req0_valid & ~grant;
      req1_ready = rst_n & (state_q == StIdle) & req1_valid & grant;
      accept     = req0_ready | req1_ready;
      sel_we     = grant ? req1_we    : req0_we;
      sel_addr   = grant ? req1_addr  : req0_addr;
      sel_wdata  = grant ? req1_wdata : req0_wdata;
   end

   // Next-state and next-output logic; outputs are registered one state ahead.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      port_d       = port_q;
      last_grant_d = last_grant_q;
      adr_d        = adr_q;
      dat_o_d      = dat_o_q;
      dat_oe_d     = dat_oe_q;
      cs_n_d       = cs_n_q;
      oe_n_d       = oe_n_q;
      we_n_d       = we_n_q;
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d      = StSetup;
               we_d         = sel_we;
               port_d       = grant;
               last_grant_d = grant;
               cs_n_d       = 1'b0;
               adr_d        = sel_addr;
               dat_oe_d     = sel_we;
               if (sel_we) begin
                  dat_o_d = sel_wdata;
               end
            end
         end
         StSetup: begin
            state_d = StStrobe;
            cnt_d   = CNT_INIT;
            if (we_q) begin
               we_n_d = 1'b0;
            end else begin
               oe_n_d = 1'b0;
            end
         end
         StStrobe: begin
            if (cnt_q == '0) begin
               // Last strobe cycle: release strobes, capture read data, signal completion.
               state_d = StHold;
               we_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               if (port_q) begin
                  rsp1_valid_d = 1'b1;
                  if (!we_q) rdata1_d = sram_dat_i;
               end else begin
                  rsp0_valid_d = 1'b1;
                  if (!we_q) rdata0_d = sram_dat_i;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StHold: begin
            // adr/dat_o stay put so the SRAM sees hold time after the strobe.
            state_d  = StIdle;
            cs_n_d   = 1'b1;
            dat_oe_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         port_q       <= 1'b0;
         last_grant_q <= 1'b1;
         adr_q        <= '0;
         dat_o_q      <= '0;
         dat_oe_q     <= 1'b0;
         cs_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         port_q       <= port_d;
         last_grant_q <= last_grant_d;
         adr_q        <= adr_d;
         dat_o_q      <= dat_o_d;
         dat_oe_q     <= dat_oe_d;
         cs_n_q       <= cs_n_d;
         oe_n_q       <= oe_n_d;
         we_n_q       <= we_n_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign sram_adr    = adr_q;
   assign sram_dat_o  = dat_o_q;
   assign sram_dat_oe = dat_oe_q;
   assign sram_cs_n   = cs_n_q;
   assign sram_oe_n   = oe_n_q;
   assign sram_we_n   = we_n_q;
   assign rsp0_valid  = rsp0_valid_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp0_rdata  = rdata0_q;
   assign rsp1_rdata  = rdata1_q;

endmodule
